// File: rtl/apb_arbiter_if.sv
// APB completer-side bus bundle for the two-requester arbiter.
// The master modport is the arbiter's view and the slave modport is the peripheral's view.
interface apb_arbiter_if;
  logic [3:0] paddr;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;

  modport master (output paddr, pwrite, psel, penable, pwdata, input prdata, pready);
  modport slave  (input paddr, pwrite, psel, penable, pwdata, output prdata, pready);
endinterface

// File: rtl/apb_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// It runs an IDLE/SETUP/ACCESS transfer and aborts the transfer after TIMEOUT_CYC stalled ACCESS cycles.
module apb_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    req_wr,
  input  logic [7:0]    req_addr,
  input  logic [15:0]   req_wdata,
  output logic [1:0]    done,
  output logic          err,
  output logic [7:0]    rdata,
  apb_arbiter_if.master apb
);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t     state_q, state_d;
  logic       psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [3:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] done_q, done_d, elig;
  logic       err_q, err_d, win_q, win_d, ptr_q, ptr_d, gnt;

  // A requester seeing its own done pulse is masked so it cannot be re-granted that cycle.
  assign elig    = req & ~done_q;
  assign gnt     = (&elig) ? ~ptr_q : elig[1];
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    done_d    = 2'b00;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d  = SETUP;
          win_d    = gnt;
          psel_d   = 1'b1;
          pwrite_d = gnt ? req_wr[1] : req_wr[0];
          paddr_d  = gnt ? req_addr[7:4] : req_addr[3:0];
          pwdata_d = gnt ? req_wdata[15:8] : req_wdata[7:0];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = 8'd0;
      end
      ACCESS: begin
        // A normal completion and a timeout share the same exit. Only err and rdata differ between them.
        if (apb.pready || cnt_inc == TO_LIM) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ptr_d     = win_q;
          done_d    = win_q ? 2'b10 : 2'b01;
          err_d     = ~apb.pready;
          if (!pwrite_q) rdata_d = apb.pready ? apb.prdata : 8'h00;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 4'h0;
      pwdata_q  <= 8'h00;
      rdata_q   <= 8'h00;
      cnt_q     <= 8'd0;
      win_q     <= 1'b0;
      ptr_q     <= 1'b1;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
endmodule

// File: tb/tb_apb_arbiter.sv
// Scenario bench for apb_arbiter. Directed cases cover each feature.
// A randomized run is scored against a transaction-level arbitration model.
module tb_apb_arbiter;
  localparam int TO = 16;

  logic        pclk, rst_n;
  logic [1:0]  req, req_wr;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  done;
  logic        err;
  logic [7:0]  rdata;
  int checks = 0, failures = 0;

  apb_arbiter_if bus();

  apb_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .apb(bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #300000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1);
  end

  task automatic do_reset();
    req = 2'b00; bus.pready = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
  endtask

  // Runs one single-requester transfer with a slave that stalls for the given number of ACCESS cycles.
  // The task only observes the bus. The caller does the comparisons.
  task automatic do_xfer(input int r, input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input int waits, input logic [7:0] rd,
                         output int n_psel, output int n_pen, output logic [1:0] dn,
                         output logic er, output logic [7:0] rdq, output logic cmd_ok, output int lat);
    @(negedge pclk);
    n_psel = 0; n_pen = 0; dn = 2'b00; er = 1'b0; rdq = 8'h00; cmd_ok = 1'b1; lat = -1;
    req_wr[r] = wr; req_addr[4*r +: 4] = a; req_wdata[8*r +: 8] = d; req[r] = 1'b1;
    bus.prdata = rd; bus.pready = (waits == 0);
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(negedge pclk);
      if (bus.psel) begin
        n_psel++;
        if (bus.paddr !== a || bus.pwrite !== wr || bus.pwdata !== d) cmd_ok = 1'b0;
      end
      if (bus.penable) begin n_pen++; bus.pready = (n_pen > waits); end
      else bus.pready = (waits == 0);
      if (done !== 2'b00) begin dn = done; er = err; rdq = rdata; lat = k; req[r] = 1'b0; end
    end
    req[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00; req_wr = 2'b00; req_addr = 8'h00; req_wdata = 16'h0000;
    bus.pready = 1'b0; bus.prdata = 8'h00;
    @(negedge pclk);
    checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL reset_psel got=%b exp=0", bus.psel); end
    checks++; if (bus.penable !== 1'b0) begin failures++; $display("FAIL reset_penable got=%b exp=0", bus.penable); end
    checks++; if (bus.pwrite !== 1'b0) begin failures++; $display("FAIL reset_pwrite got=%b exp=0", bus.pwrite); end
    checks++; if (bus.paddr !== 4'h0) begin failures++; $display("FAIL reset_paddr got=%h exp=0", bus.paddr); end
    checks++; if (bus.pwdata !== 8'h00) begin failures++; $display("FAIL reset_pwdata got=%h exp=0", bus.pwdata); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge pclk);
      checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL idle_no_grant got=%b exp=0", bus.psel); end
    end
  endtask

  task automatic test_write();
    int np, ne, lat; logic [1:0] dn; logic er, ok; logic [7:0] rq;
    do_xfer(0, 1'b1, 4'h2, 8'h05, 0, 8'h00, np, ne, dn, er, rq, ok, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (np !== 2) begin failures++; $display("FAIL wr_psel_cycles got=%0d exp=2", np); end
    checks++; if (ne !== 1) begin failures++; $display("FAIL wr_penable_cycles got=%0d exp=1", ne); end
    checks++; if (dn !== 2'b01) begin failures++; $display("FAIL wr_done got=%b exp=01", dn); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", er); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_cmd_stable got=%b exp=1", ok); end
  endtask

  task automatic test_read_wait();
    int np, ne, lat; logic [1:0] dn; logic er, ok; logic [7:0] rq;
    do_xfer(1, 1'b0, 4'h3, 8'h77, 2, 8'h0A, np, ne, dn, er, rq, ok, lat);
    checks++; if (ne !== 3) begin failures++; $display("FAIL rd_penable_cycles got=%0d exp=3", ne); end
    checks++; if (np !== 4) begin failures++; $display("FAIL rd_psel_cycles got=%0d exp=4", np); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL rd_latency got=%0d exp=5", lat); end
    checks++; if (dn !== 2'b10) begin failures++; $display("FAIL rd_done got=%b exp=10", dn); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", er); end
    checks++; if (rq !== 8'h0A) begin failures++; $display("FAIL rd_rdata got=%h exp=0a", rq); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rd_cmd_stable got=%b exp=1", ok); end
  endtask

  task automatic test_timeout();
    int np, ne, lat; logic [1:0] dn; logic er, ok; logic [7:0] rq;
    // The last possible ready cycle completes normally.
    do_xfer(1, 1'b0, 4'h6, 8'h00, TO-1, 8'h3C, np, ne, dn, er, rq, ok, lat);
    checks++; if (ne !== TO) begin failures++; $display("FAIL edge_penable got=%0d exp=%0d", ne, TO); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL edge_err got=%b exp=0", er); end
    checks++; if (rq !== 8'h3C) begin failures++; $display("FAIL edge_rdata got=%h exp=3c", rq); end
    do_xfer(0, 1'b0, 4'h1, 8'h00, TO, 8'hFF, np, ne, dn, er, rq, ok, lat);
    checks++; if (ne !== TO) begin failures++; $display("FAIL to_penable got=%0d exp=%0d", ne, TO); end
    checks++; if (dn !== 2'b01) begin failures++; $display("FAIL to_done got=%b exp=01", dn); end
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", er); end
    checks++; if (rq !== 8'h00) begin failures++; $display("FAIL to_rdata got=%h exp=00", rq); end
    checks++; if (lat !== TO+2) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", lat, TO+2); end
    do_xfer(0, 1'b0, 4'h4, 8'h00, 0, 8'hA5, np, ne, dn, er, rq, ok, lat);
    checks++; if (rq !== 8'hA5) begin failures++; $display("FAIL rd2_rdata got=%h exp=a5", rq); end
    do_xfer(1, 1'b1, 4'h8, 8'h99, 1000, 8'h11, np, ne, dn, er, rq, ok, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL wto_err got=%b exp=1", er); end
    checks++; if (rq !== 8'hA5) begin failures++; $display("FAIL wto_rdata_kept got=%h exp=a5", rq); end
  endtask

  task automatic test_alternate();
    int nd; logic [1:0] dv[4]; int dk[4];
    do_reset();
    nd = 0;
    req_wr = 2'b01; req_addr = 8'h94; req_wdata = 16'h2211; bus.pready = 1'b1; req = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      @(negedge pclk);
      if (done !== 2'b00 && nd < 4) begin dv[nd] = done; dk[nd] = k; nd++; end
    end
    req = 2'b00;
    checks++; if (nd !== 4) begin failures++; $display("FAIL alt_count got=%0d exp=4", nd); end
    for (int i = 0; i < nd; i++) begin
      checks++;
      if (dv[i] !== ((i % 2) ? 2'b10 : 2'b01) || dk[i] !== 3*(i+1)) begin
        failures++; $display("FAIL alt_grant%0d got=%b@%0d exp=%b@%0d", i, dv[i], dk[i], (i % 2) ? 2'b10 : 2'b01, 3*(i+1));
      end
    end
  endtask

  task automatic test_hold_no_regrant();
    int nd, g2; int dk[2];
    do_reset();
    nd = 0; g2 = -1; dk[0] = -1; dk[1] = -1;
    bus.pready = 1'b1; req_wr[0] = 1'b1; req_addr[3:0] = 4'h7; req_wdata[7:0] = 8'h42; req = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      @(negedge pclk);
      if (done !== 2'b00) begin if (nd < 2) dk[nd] = k; nd++; end
      if (bus.psel && nd == 1 && g2 < 0) begin g2 = k; req = 2'b00; end
    end
    req = 2'b00;
    checks++; if (nd !== 2) begin failures++; $display("FAIL hold_done_count got=%0d exp=2", nd); end
    checks++; if (dk[0] !== 3) begin failures++; $display("FAIL hold_first_done got=%0d exp=3", dk[0]); end
    checks++; if (g2 !== 5) begin failures++; $display("FAIL hold_regrant_cycle got=%0d exp=5", g2); end
    checks++; if (dk[1] !== 7) begin failures++; $display("FAIL hold_second_done got=%0d exp=7", dk[1]); end
  endtask

  task automatic test_reset_mid();
    int k, np, ne, lat; logic [1:0] dn; logic er, ok; logic [7:0] rq;
    do_reset();
    req_wr[0] = 1'b0; req_addr[3:0] = 4'h9; bus.pready = 1'b0; req = 2'b01;
    k = 0;
    while (!bus.penable && k < 20) begin @(negedge pclk); k++; end
    checks++; if (k >= 20) begin failures++; $display("FAIL mid_access_reached got=%0d exp=<20", k); end
    repeat (2) @(negedge pclk);
    #2 rst_n = 1'b0; req = 2'b00;
    #1;
    checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL mid_psel got=%b exp=0", bus.psel); end
    checks++; if (bus.penable !== 1'b0) begin failures++; $display("FAIL mid_penable got=%b exp=0", bus.penable); end
    repeat (2) begin
      @(negedge pclk);
      checks++; if (done !== 2'b00) begin failures++; $display("FAIL mid_no_done got=%b exp=00", done); end
    end
    rst_n = 1'b1;
    do_xfer(0, 1'b1, 4'hC, 8'h3E, 0, 8'h00, np, ne, dn, er, rq, ok, lat);
    checks++; if (dn !== 2'b01 || er !== 1'b0) begin failures++; $display("FAIL mid_after_done got=%b/%b exp=01/0", dn, er); end
    checks++; if (lat !== 3 || np !== 2) begin failures++; $display("FAIL mid_after_timing got=%0d/%0d exp=3/2", lat, np); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_after_cmd got=%b exp=1", ok); end
  endtask

  // Model: a transfer round has 1 or 2 requesters. The one not served last goes first.
  // Each transfer lasts min(waits+1, TO) ACCESS cycles and errors when waits >= TO.
  task automatic test_random();
    logic ptr_m, cmd_ok, exp_err; logic [7:0] rdata_m; int order[$];
    logic wr[2]; logic [3:0] a[2]; logic [7:0] d[2]; logic [7:0] rd[2]; int w[2];
    int pres, cur, npen, npsel, k, exp_pen;
    do_reset();
    ptr_m = 1'b1; rdata_m = 8'h00;
    for (int round = 0; round < 40; round++) begin
      pres = $urandom_range(1, 3);
      order.delete();
      for (int i = 0; i < 2; i++) begin
        wr[i] = 1'($urandom); a[i] = 4'($urandom); d[i] = 8'($urandom); rd[i] = 8'($urandom);
        w[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(TO-1, TO+3) : $urandom_range(0, 3);
        if (pres[i]) begin
          req_wr[i] = wr[i]; req_addr[4*i +: 4] = a[i]; req_wdata[8*i +: 8] = d[i]; req[i] = 1'b1;
        end
      end
      if (pres == 3) begin order.push_back(ptr_m ? 0 : 1); order.push_back(ptr_m ? 1 : 0); end
      else order.push_back(pres == 2 ? 1 : 0);
      npen = 0; npsel = 0; cmd_ok = 1'b1; k = 0;
      while (order.size() > 0 && k < 200) begin
        @(negedge pclk); k++;
        cur = order[0];
        bus.prdata = rd[cur];
        if (bus.psel) begin
          npsel++;
          if (bus.paddr !== a[cur] || bus.pwrite !== wr[cur] || bus.pwdata !== d[cur]) cmd_ok = 1'b0;
        end
        if (bus.penable) begin npen++; bus.pready = (npen > w[cur]); end
        else bus.pready = 1'($urandom);
        if (done !== 2'b00) begin
          exp_err = (w[cur] >= TO);
          exp_pen = exp_err ? TO : w[cur] + 1;
          if (!wr[cur]) rdata_m = exp_err ? 8'h00 : rd[cur];
          checks++; if (done !== (cur ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rnd_done r%0d got=%b exp=%b", round, done, cur ? 2'b10 : 2'b01); end
          checks++; if (err !== exp_err) begin failures++; $display("FAIL rnd_err r%0d got=%b exp=%b", round, err, exp_err); end
          checks++; if (rdata !== rdata_m) begin failures++; $display("FAIL rnd_rdata r%0d got=%h exp=%h", round, rdata, rdata_m); end
          checks++; if (npen !== exp_pen) begin failures++; $display("FAIL rnd_penable r%0d got=%0d exp=%0d", round, npen, exp_pen); end
          checks++; if (npsel !== exp_pen + 1) begin failures++; $display("FAIL rnd_psel r%0d got=%0d exp=%0d", round, npsel, exp_pen + 1); end
          checks++; if (bus.psel !== 1'b0) begin failures++; $display("FAIL rnd_idle_gap r%0d got=%b exp=0", round, bus.psel); end
          checks++; if (cmd_ok !== 1'b1) begin failures++; $display("FAIL rnd_cmd r%0d got=%b exp=1", round, cmd_ok); end
          req[cur] = 1'b0; ptr_m = cur[0];
          void'(order.pop_front());
          npen = 0; npsel = 0; cmd_ok = 1'b1;
        end
      end
      checks++; if (order.size() != 0) begin failures++; $display("FAIL rnd_stall r%0d got=%0d_pending exp=0", round, order.size()); end
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_alternate();
    test_hold_no_regrant();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
